data_read_axi_regwrite: RTL and testbench
=========================================

Name: data_read_axi_regwrite

Overview:
- Parametrised AXI4-lite write-channel slave for the data_read peripheral; successor to the single-register CR-only write path.
- Decodes a bank of NUM_REGS 32-bit control registers and accepts AW and W in either order.
- Returns OKAY/SLVERR per address, produces per-register write strobes, and generates a self-clearing CR.START pulse.
- Sits between the AXI interconnect and the data_read control logic; read path is a separate block.

Parameters:
- NUM_REGS, 4, number of 32-bit registers (1..16); register 0 is CR.
- ADDR_W, 8, significant AWADDR bits decoded; any set bit above ADDR_W-1 gives SLVERR.
- RST_VAL, 32'h0000_0000, reset value of every register.

Ports:
- S_AXI_ACLK  in  1  clock; everything on rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  32  write address.
- S_AXI_AWVALID  in  1  address valid.
- S_AXI_AWREADY  out  1  address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  data valid.
- S_AXI_WREADY  out  1  data ready.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1  response valid.
- S_AXI_BREADY  in  1  response ready.
- reg_q  out  32*NUM_REGS  register contents; reg i at bits [32i+31:32i].
- wr_pulse  out  NUM_REGS  one-cycle strobe, bit i = reg i written.
- cr_start  out  1  one-cycle pulse when CR bit0 is written as 1.

Behaviour:
- Clock and reset: one clock S_AXI_ACLK; reset S_AXI_ARESET is asynchronous and active-high.
- Reset values: state IDLE; all regs RST_VAL; AWREADY=WREADY=BVALID=0; BRESP=00; wr_pulse=0; cr_start=0; aw_held=w_held=0.
- States: IDLE, COMMIT, RESP.
- IDLE:
  - AWREADY = !aw_held; WREADY = !w_held.
  - A handshake (VALID&&READY) latches AWADDR or WDATA/WSTRB and sets the matching held flag.
  - AW and W may complete in the same cycle or in either order, any gap between them.
  - Go to COMMIT on the edge where both are held, counting a handshake in the current cycle.
- COMMIT (1 cycle):
  - AWREADY=WREADY=0.
  - Decode idx = addr[ADDR_W-1:2].
  - Error if addr[1:0]!=0, or addr[31:ADDR_W]!=0, or idx>=NUM_REGS: no register change, resp=10.
  - Otherwise update reg idx bytewise by WSTRB, set resp=00, and register wr_pulse[idx]=1 for the next cycle.
  - Clear held flags; go to RESP.
- RESP:
  - BVALID=1, BRESP=resp; held stable until BREADY.
  - On BVALID&&BREADY go to IDLE.
  - AWREADY=WREADY=0, so no new beat is accepted in RESP.
- Latency: both handshakes at cycle t → register updated at end of t+1 → BVALID, wr_pulse, cr_start high in cycle t+2. Minimum 3 cycles per write with BREADY held high.
- CR bit0 (START):
  - Self-clearing; never reads back as 1.
  - cr_start = 1 for exactly one cycle when a valid write to reg 0 has WSTRB[0]=1 and WDATA[0]=1.
  - reg_q bit0 of CR stays 0.
- Other regs hold their value until rewritten.
- wr_pulse and cr_start: registered, one cycle, deasserted at all other times, including on SLVERR writes.
- BRESP = 00 whenever BVALID=0.
- Reset asserted mid-transaction: immediate return to reset values. A partially captured AW/W is discarded and no response is issued.
- A write with WSTRB=0 to a valid address gives OKAY, leaves the register unchanged, and still pulses wr_pulse.

Optional Feature:
- Macro DATA_READ_AXI_WSTRB_EN.
- Defined: byte strobes honoured as above.
- Undefined: WSTRB ignored and every valid write updates all 4 bytes; cr_start depends only on WDATA[0].

Test Plan:
- Simultaneous AW/W to 0x04, data 0xA5A5_1234, WSTRB=F, BREADY=1 → reg_q[63:32]=0xA5A5_1234, wr_pulse=0010 for 1 cycle, BVALID 2 cycles after handshake, BRESP=00.
- W first (0xDEAD_BEEF), AW to 0x08 three cycles later → WREADY low after W handshake; reg 2=0xDEAD_BEEF; single OKAY response.
- Write 0x0000_0001 to 0x00 → cr_start high exactly 1 cycle coincident with BVALID; CR bit0 reads 0; second write repeats the pulse.
- Write to 0x10 (NUM_REGS=4) and to 0x06 → BRESP=10, no reg change, no wr_pulse, no cr_start.
- BREADY held low 5 cycles → BVALID and BRESP stable; AWREADY/WREADY stay 0; new AW offered is not accepted until after the B handshake.
- Reg 1=0xFFFF_FFFF, write 0x1122_3344 with WSTRB=0101 (macro defined) → 0xFF22_FF44; macro undefined → 0x1122_3344. Reset asserted in COMMIT → all regs RST_VAL, BVALID never rises.

Source files
------------

// File: rtl/data_read_axi_regwrite_if.sv
// AXI4-lite write-channel bundle (AW, W, B) for the data_read register block.
interface data_read_axi_regwrite_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );
endinterface

// File: rtl/data_read_axi_regwrite.sv
// AXI4-lite write slave for the data_read control register bank.
// AW and W accepted in any order; OKAY/SLVERR per address; per-register
// write strobes and a self-clearing CR.START pulse.
// Optional macro DATA_READ_AXI_WSTRB_EN: when defined, WSTRB byte strobes are
// honoured; when undefined every valid write updates all four bytes.
module data_read_axi_regwrite #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  data_read_axi_regwrite_if.slave    axi,
  output logic [32*NUM_REGS-1:0]     reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic                       cr_start
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned VEC_W = 32 * NUM_REGS;
  // CR.START never reads back as 1, even out of reset.
  localparam logic [VEC_W-1:0] RST_VEC = {NUM_REGS{RST_VAL}} & ~(VEC_W'(1));

  typedef enum logic [1:0] {IDLE, COMMIT, RESP} state_t;

  state_t      state;
  logic        aw_held, w_held;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [31:0] aw_addr_q, wdata_q;
  logic [3:0]  wstrb_q;

  logic             aw_hs_c, w_hs_c, aw_got_c, w_got_c;
  logic [IDX_W-1:0] idx_c;
  logic             addr_err_c;
  logic [3:0]       strb_eff_c;
  logic             start_c;

  assign axi.S_AXI_AWREADY = awready_q;
  assign axi.S_AXI_WREADY  = wready_q;
  assign axi.S_AXI_BVALID  = bvalid_q;
  assign axi.S_AXI_BRESP   = bresp_q;

  // Handshake detection and address decode of the captured beat.
  always_comb begin
    aw_hs_c    = axi.S_AXI_AWVALID && awready_q;
    w_hs_c     = axi.S_AXI_WVALID && wready_q;
    aw_got_c   = aw_held || aw_hs_c;
    w_got_c    = w_held || w_hs_c;
    idx_c      = aw_addr_q[ADDR_W-1:2];
    addr_err_c = (aw_addr_q[1:0] != 2'b00) ||
                 ((aw_addr_q >> ADDR_W) != 32'd0) ||
                 (32'(idx_c) >= NUM_REGS);
`ifdef DATA_READ_AXI_WSTRB_EN
    strb_eff_c = wstrb_q;
`else
    // Strobes ignored: every byte lane is written.
    strb_eff_c = wstrb_q | 4'hF;
`endif
    start_c    = !addr_err_c && (idx_c == '0) && strb_eff_c[0] && wdata_q[0];
  end

  // Write FSM: capture AW/W, commit to the register bank, hold the response.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state     <= IDLE;
      reg_q     <= RST_VEC;
      wr_pulse  <= '0;
      cr_start  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_addr_q <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else begin
      wr_pulse <= '0;
      cr_start <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_hs_c) begin
            aw_addr_q <= axi.S_AXI_AWADDR;
            aw_held   <= 1'b1;
          end
          if (w_hs_c) begin
            wdata_q <= axi.S_AXI_WDATA;
            wstrb_q <= axi.S_AXI_WSTRB;
            w_held  <= 1'b1;
          end
          if (aw_got_c && w_got_c) begin
            state     <= COMMIT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= !aw_got_c;
            wready_q  <= !w_got_c;
          end
        end
        COMMIT: begin
          aw_held  <= 1'b0;
          w_held   <= 1'b0;
          bvalid_q <= 1'b1;
          state    <= RESP;
          if (addr_err_c) begin
            bresp_q <= 2'b10;
          end else begin
            bresp_q  <= 2'b00;
            cr_start <= start_c;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
              if (idx_c == IDX_W'(i)) begin
                wr_pulse[i] <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                  if (strb_eff_c[b]) reg_q[32*i+8*b +: 8] <= wdata_q[8*b +: 8];
                end
                if (i == 0) reg_q[0] <= 1'b0;
              end
            end
          end
        end
        RESP: begin
          if (axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            state     <= IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_read_axi_regwrite.sv
// Scoreboard bench for data_read_axi_regwrite: directed writes push expected
// B responses; a negedge monitor pops and compares when BVALID rises.
module tb_data_read_axi_regwrite;

`ifdef DATA_READ_AXI_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_read_axi_regwrite_if axi();
  logic [127:0] reg_q;
  logic [3:0]   wr_pulse;
  logic         cr_start;

  data_read_axi_regwrite #(
    .NUM_REGS(4),
    .ADDR_W  (8),
    .RST_VAL (32'h0000_0000)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .axi         (axi),
    .reg_q       (reg_q),
    .wr_pulse    (wr_pulse),
    .cr_start    (cr_start)
  );

  typedef struct {
    logic [1:0]   resp;
    logic [3:0]   pulse;
    logic         cr;
    logic [127:0] regs;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_regs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic logic [127:0] exp_vec();
    return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
  endfunction

  // Monitor: compare on the first BVALID cycle, otherwise pulses must be low.
  logic prev_bv = 1'b0;
  logic [1:0] prev_br = 2'b00;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_bv = 1'b0;
      prev_br = 2'b00;
    end else begin
      if (axi.S_AXI_BVALID && !prev_bv) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bvalid: got BVALID=1 expected no response (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("bresp",    128'(axi.S_AXI_BRESP), 128'(mon_e.resp));
          chk("wr_pulse", 128'(wr_pulse),        128'(mon_e.pulse));
          chk("cr_start", 128'(cr_start),        128'(mon_e.cr));
          chk("reg_q",    reg_q,                 mon_e.regs);
        end
      end else begin
        chk("wr_pulse_quiet", 128'(wr_pulse), 128'(0));
        chk("cr_start_quiet", 128'(cr_start), 128'(0));
        if (axi.S_AXI_BVALID) chk("bresp_stable", 128'(axi.S_AXI_BRESP), 128'(prev_br));
        else                  chk("bresp_idle",   128'(axi.S_AXI_BRESP), 128'(0));
      end
      prev_bv = axi.S_AXI_BVALID;
      prev_br = axi.S_AXI_BRESP;
    end
  end

  task automatic drive_aw(input logic [31:0] a, input int dly);
    bit got = 1'b0;
    int n = 0;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    axi.S_AXI_AWADDR  = a;
    axi.S_AXI_AWVALID = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (axi.S_AXI_AWREADY) got = 1'b1;
    end
    if (!got) timeout("aw_handshake");
    @(posedge clk);
    #1 axi.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit got = 1'b0;
    int n = 0;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    axi.S_AXI_WDATA  = d;
    axi.S_AXI_WSTRB  = s;
    axi.S_AXI_WVALID = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (axi.S_AXI_WREADY) got = 1'b1;
    end
    if (!got) timeout("w_handshake");
    @(posedge clk);
    #1 axi.S_AXI_WVALID = 1'b0;
  endtask

  // Wait for BVALID, optionally stall BREADY while probing that AW is refused.
  task automatic wait_b(input int hold);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!axi.S_AXI_BVALID && n < 50);
    if (!axi.S_AXI_BVALID) begin
      timeout("bvalid");
      axi.S_AXI_BREADY = 1'b1;
      return;
    end
    if (hold > 0) begin
      axi.S_AXI_AWADDR  = 32'h0000_0004;
      axi.S_AXI_AWVALID = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk("bvalid_hold",  128'(axi.S_AXI_BVALID),  128'(1));
        chk("awready_hold", 128'(axi.S_AXI_AWREADY), 128'(0));
        chk("wready_hold",  128'(axi.S_AXI_WREADY),  128'(0));
      end
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_BREADY  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] resp, input int idx, input logic [31:0] val,
                          input logic [3:0] pulse, input logic cr);
    exp_t e;
    if (resp == 2'b00) exp_regs[idx] = val;
    e.resp  = resp;
    e.pulse = pulse;
    e.cr    = cr;
    e.regs  = exp_vec();
    sb.push_back(e);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold,
                          input logic [1:0] resp, input int idx, input logic [31:0] val,
                          input logic [3:0] pulse, input logic cr);
    push_exp(resp, idx, val, pulse, cr);
    axi.S_AXI_BREADY = (hold == 0);
    fork
      drive_aw(addr, aw_dly);
      drive_w(data, strb, w_dly);
    join
    wait_b(hold);
  endtask

  initial begin
    rst = 1'b1;
    axi.S_AXI_AWADDR  = 32'd0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = 32'd0;
    axi.S_AXI_WSTRB   = 4'd0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b1;
    for (int i = 0; i < 4; i++) exp_regs[i] = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_reg_q",    reg_q,                      128'(0));
    chk("rst_awready",  128'(axi.S_AXI_AWREADY),    128'(0));
    chk("rst_wready",   128'(axi.S_AXI_WREADY),     128'(0));
    chk("rst_bvalid",   128'(axi.S_AXI_BVALID),     128'(0));
    chk("rst_bresp",    128'(axi.S_AXI_BRESP),      128'(0));
    chk("rst_wr_pulse", 128'(wr_pulse),             128'(0));
    chk("rst_cr_start", 128'(cr_start),             128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous AW/W to reg 1
    do_write(32'h04, 32'hA5A5_1234, 4'hF, 0, 0, 0, 2'b00, 1, 32'hA5A5_1234, 4'b0010, 1'b0);

    // W first, AW three cycles later, to reg 2
    push_exp(2'b00, 2, 32'hDEAD_BEEF, 4'b0100, 1'b0);
    fork
      drive_aw(32'h08, 3);
      drive_w(32'hDEAD_BEEF, 4'hF, 0);
      begin
        repeat (2) @(negedge clk);
        chk("wready_after_w",  128'(axi.S_AXI_WREADY),  128'(0));
        chk("awready_waiting", 128'(axi.S_AXI_AWREADY), 128'(1));
      end
    join
    wait_b(0);

    // CR.START pulses, bit0 reads back 0; twice
    do_write(32'h00, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 0, 32'h0000_0000, 4'b0001, 1'b1);
    do_write(32'h00, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 0, 32'h0000_0000, 4'b0001, 1'b1);

    // Decode errors: out of range, misaligned, upper address bit set
    do_write(32'h10,  32'h1111_1111, 4'hF, 0, 0, 0, 2'b10, 0, 32'h0, 4'b0000, 1'b0);
    do_write(32'h06,  32'h2222_2222, 4'hF, 0, 0, 0, 2'b10, 0, 32'h0, 4'b0000, 1'b0);
    do_write(32'h104, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b10, 0, 32'h0, 4'b0000, 1'b0);

    // BREADY stalled 5 cycles, AW offered meanwhile must be refused
    do_write(32'h0C, 32'h1234_5678, 4'hF, 0, 0, 5, 2'b00, 3, 32'h1234_5678, 4'b1000, 1'b0);

    // Byte strobes
    do_write(32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00, 1, 32'hFFFF_FFFF, 4'b0010, 1'b0);
    do_write(32'h04, 32'h1122_3344, 4'b0101, 0, 0, 0, 2'b00, 1,
             STRB_EN ? 32'hFF22_FF44 : 32'h1122_3344, 4'b0010, 1'b0);
    do_write(32'h08, 32'h0BAD_0BAD, 4'b0000, 0, 0, 0, 2'b00, 2,
             STRB_EN ? 32'hDEAD_BEEF : 32'h0BAD_0BAD, 4'b0100, 1'b0);
    do_write(32'h00, 32'h0000_0101, 4'b1110, 0, 0, 0, 2'b00, 0,
             32'h0000_0100, 4'b0001, STRB_EN ? 1'b0 : 1'b1);

    // AW first, W two cycles later
    do_write(32'h0C, 32'h55AA_55AA, 4'hF, 0, 2, 0, 2'b00, 3, 32'h55AA_55AA, 4'b1000, 1'b0);

    // Reset during COMMIT: write discarded, no response
    fork
      drive_aw(32'h04, 0);
      drive_w(32'hCAFE_F00D, 4'hF, 0);
    join
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_regs[i] = 32'd0;
    @(negedge clk);
    chk("midrst_reg_q",  reg_q,                   exp_vec());
    chk("midrst_bvalid", 128'(axi.S_AXI_BVALID),  128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_bvalid", 128'(axi.S_AXI_BVALID), 128'(0));
    end
    chk("post_rst_reg_q", reg_q, exp_vec());
    @(posedge clk);
    #1;

    // Recovery write after reset
    do_write(32'h04, 32'h00C0_FFEE, 4'hF, 0, 0, 0, 2'b00, 1, 32'h00C0_FFEE, 4'b0010, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
